timer_alarm_ctrl: RTL
=====================

Name: timer_alarm_ctrl

Overview:
Multi-channel alarm scheduler layered on the shared free-running counter. It lets several software or hardware requesters share one WIDTH-bit counter. Each channel is armed with a relative delay and raises a pending flag when the counter reaches its deadline, either one-shot or periodic. The block sits between the free-running counter and the interrupt/event logic.

Parameters:
WIDTH, 32, width of the counter value and delays.
CHANNELS, 4, number of independent alarm channels.
CH_BITS, 2, width of the channel index; must satisfy 2^CH_BITS >= CHANNELS.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
count  in  WIDTH  current value of the free-running counter
cmd_valid  in  1  command strobe; accepted when cmd_valid && cmd_ready
cmd_op  in  2  0=ARM_ONESHOT, 1=ARM_PERIODIC, 2=CANCEL, 3=ACK
cmd_ch  in  CH_BITS  target channel; values >= CHANNELS are ignored (no effect)
cmd_delay  in  WIDTH  relative delay for ARM_* commands; MSB forced to 0 internally
cmd_ready  out  1  registered; 0 during reset and for the cycle after, 1 afterwards
armed  out  CHANNELS  per-channel, 1 while the channel is in ARMED
pending  out  CHANNELS  per-channel sticky alarm flag
overrun  out  CHANNELS  per-channel sticky flag: a periodic fire occurred while pending was already set
irq  out  1  OR of pending, registered and aligned with pending

Behaviour:
- Single clock domain; all outputs registered. Synchronous active-high reset, effective at any time including mid-operation.
- Reset values: cmd_ready=0, armed=0, pending=0, overrun=0, irq=0. All channels go to IDLE; deadlines and periods are cleared to 0.
- Per-channel FSM with states IDLE, ARMED, PENDING (PENDING applies to one-shot only).
- Effective delay d = {1'b0, cmd_delay[WIDTH-2:0]}.
- ARM_* accepted at edge E, with count=C sampled at E:
  - deadline <= C + d (mod 2^WIDTH); period <= d; mode is latched.
  - State -> ARMED; pending and overrun for the channel are cleared.
  - Re-arming an ARMED or PENDING channel overwrites the previous arm.
- Fire test (ARMED only, evaluated every cycle on the sampled count): diff = count - deadline (mod 2^WIDTH); fire when diff[WIDTH-1]==0. This makes the test wrap-safe for distances < 2^(WIDTH-1).
- Delay 0 fires on the first evaluation after arming: the cycle following acceptance, since diff=1 there with a free-running counter.
- Fire latency: with count==deadline presented at edge k, pending (and irq) are 1 after edge k.
- One-shot fire: pending <= 1; state -> PENDING; armed bit -> 0.
- Periodic fire:
  - deadline <= deadline + period, not count + period, so there is no drift.
  - State stays ARMED.
  - If pending was already 1, overrun <= 1; then pending <= 1.
  - period 0 therefore fires every cycle once reached.
- ACK: clears pending and overrun. PENDING -> IDLE; ARMED stays ARMED.
- CANCEL: state -> IDLE; clears pending and overrun.
- A command on a channel in the same cycle as that channel's fire: the command wins and the fire is discarded. Other channels fire normally in that cycle.
- ACK or CANCEL on an IDLE channel is a no-op.
- Exactly one command is accepted per cycle. Commands while cmd_ready=0 are dropped.
- The deadline + period addition wraps modulo 2^WIDTH; there is no saturation.

Test Plan:
- Reset release: hold reset 3 cycles -> all outputs 0 during reset. cmd_ready=0 in the first cycle after reset deasserts, then 1.
- One-shot: count=100, ARM_ONESHOT ch0 delay 10 -> armed[0]=1 next cycle. pending[0]=irq=1 after the edge where count=110, not before. ACK ch0 -> pending[0]=0, armed[0]=0.
- Periodic wrap: count=32'hFFFFFFFD, ARM_PERIODIC ch1 delay 5 -> fires after count=2, then after count=7 and count=12. Without ACK, the second fire sets overrun[1]=1. ACK clears both flags; armed[1] stays 1.
- Collision: ch2 armed to fire at count=50; CANCEL ch2 presented at count=50 -> pending[2] never sets, armed[2]=0. ch3 firing at count=50 in the same cycle still sets pending[3].
- Delay MSB masking / delay 0: ARM ch0 delay 32'h80000004 at count=0 -> fires after count=4. ARM ch0 delay 0 -> pending[0]=1 one cycle after acceptance.
- Reset mid-operation: two channels ARMED and one PENDING, then assert reset 1 cycle -> all flags 0, channels IDLE, no fire after the old deadlines pass.

Source files
------------

// File: rtl/timer_alarm_ctrl.sv
// timer_alarm_ctrl
//   Multi-channel alarm scheduler sharing one free-running counter. Each
//   channel is armed with a relative delay and raises a sticky pending flag
//   when the counter reaches its deadline, either one-shot or periodic.
//
// Ports
//   clk        system clock
//   reset      synchronous, active-high reset
//   count      current value of the free-running counter
//   cmd_valid  command strobe, accepted when cmd_valid && cmd_ready
//   cmd_op     0=ARM_ONESHOT 1=ARM_PERIODIC 2=CANCEL 3=ACK
//   cmd_ch     target channel (indices >= CHANNELS match nothing)
//   cmd_delay  relative delay for ARM commands (MSB ignored)
//   cmd_ready  registered; low during reset and the cycle after
//   armed      per-channel, high while the channel is ARMED
//   pending    per-channel sticky alarm flag
//   overrun    per-channel sticky flag: periodic fire while still pending
//   irq        OR of pending, registered in step with pending
module timer_alarm_ctrl #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned CH_BITS  = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [WIDTH-1:0]    count,
  input  logic                cmd_valid,
  input  logic [1:0]          cmd_op,
  input  logic [CH_BITS-1:0]  cmd_ch,
  input  logic [WIDTH-1:0]    cmd_delay,
  output logic                cmd_ready,
  output logic [CHANNELS-1:0] armed,
  output logic [CHANNELS-1:0] pending,
  output logic [CHANNELS-1:0] overrun,
  output logic                irq
);

  typedef enum logic [1:0] {
    OP_ARM_ONESHOT  = 2'd0,
    OP_ARM_PERIODIC = 2'd1,
    OP_CANCEL       = 2'd2,
    OP_ACK          = 2'd3
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARMED,
    ST_PENDING
  } ch_state_t;

  // Distances of half the counter range or more are treated as "not yet".
  localparam logic [WIDTH-1:0] HALF = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] DMASK = {1'b0, {(WIDTH-1){1'b1}}};

  op_t                op;
  logic               cmd_accept;
  logic [WIDTH-1:0]   d_eff;
  logic [CHANNELS-1:0] pending_nxt;

  assign op         = op_t'(cmd_op);
  assign cmd_accept = cmd_valid && cmd_ready;
  assign d_eff      = cmd_delay & DMASK;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    ch_state_t        state;
    logic [WIDTH-1:0] deadline;
    logic [WIDTH-1:0] period;
    logic             periodic;
    logic             arm_q;
    logic             pend_q;
    logic             ovr_q;
    logic             pend_nxt;
    logic             sel;
    logic             fire;

    assign sel  = cmd_accept && (cmd_ch == CH_BITS'(g));
    // Wrap-safe "count has reached deadline": sign bit of the modular difference.
    assign fire = (state == ST_ARMED) && ((count - deadline) < HALF);

    // Any command on the channel clears pending and takes priority over a
    // simultaneous fire (an IDLE channel never holds pending, so ACK on IDLE
    // is still a no-op).
    always_comb begin
      pend_nxt = pend_q;
      if (sel)
        pend_nxt = 1'b0;
      else if (fire)
        pend_nxt = 1'b1;
    end

    assign pending_nxt[g] = pend_nxt;
    assign armed[g]       = arm_q;
    assign pending[g]     = pend_q;
    assign overrun[g]     = ovr_q;

    always_ff @(posedge clk) begin
      if (reset) begin
        state    <= ST_IDLE;
        deadline <= '0;
        period   <= '0;
        periodic <= 1'b0;
        arm_q    <= 1'b0;
        pend_q   <= 1'b0;
        ovr_q    <= 1'b0;
      end else begin
        pend_q <= pend_nxt;
        if (sel) begin
          unique case (op)
            OP_ARM_ONESHOT, OP_ARM_PERIODIC: begin
              deadline <= count + d_eff;
              period   <= d_eff;
              periodic <= (op == OP_ARM_PERIODIC);
              state    <= ST_ARMED;
              arm_q    <= 1'b1;
              ovr_q    <= 1'b0;
            end
            OP_CANCEL: begin
              state <= ST_IDLE;
              arm_q <= 1'b0;
              ovr_q <= 1'b0;
            end
            OP_ACK: begin
              ovr_q <= 1'b0;
              if (state == ST_PENDING)
                state <= ST_IDLE;
            end
          endcase
        end else if (fire) begin
          if (periodic) begin
            // Advance from the old deadline, not from count, so no drift accumulates.
            deadline <= deadline + period;
            ovr_q    <= ovr_q | pend_q;
          end else begin
            state <= ST_PENDING;
            arm_q <= 1'b0;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cmd_ready <= 1'b0;
      irq       <= 1'b0;
    end else begin
      cmd_ready <= 1'b1;
      irq       <= |pending_nxt;
    end
  end

endmodule
